// File: rtl/cache_arbiter.sv
// cache_arbiter: round-robin arbiter sharing one memory line port
// between the I-cache and D-cache controllers.
module cache_arbiter #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_read,
    input  logic              i_write,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [LINE_W-1:0] i_wdata,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_resp
);
    typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_last_d;
    logic                w_last_d_nxt;
    logic                r_mem_read;
    logic                w_mem_read_nxt;
    logic                r_mem_write;
    logic                w_mem_write_nxt;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [ADDR_W-1:0]   w_mem_addr_nxt;
    logic [LINE_W-1:0]   r_mem_wdata;
    logic [LINE_W-1:0]   w_mem_wdata_nxt;
    logic                w_i_act;
    logic                w_d_act;
    logic                w_pick_d;

    assign w_i_act  = i_read | i_write;
    assign w_d_act  = d_read | d_write;
    // On a tie the requester that lost the previous grant goes first
    assign w_pick_d = w_d_act & (~w_i_act | ~r_last_d);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_last_d    <= 1'b1;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_last_d    <= w_last_d_nxt;
            r_mem_read  <= w_mem_read_nxt;
            r_mem_write <= w_mem_write_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_last_d_nxt    = r_last_d;
        w_mem_read_nxt  = r_mem_read;
        w_mem_write_nxt = r_mem_write;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        unique case (r_state)
            IDLE: begin
                if (w_i_act | w_d_act) begin
                    w_state_nxt     = w_pick_d ? GRANT_D : GRANT_I;
                    w_last_d_nxt    = w_pick_d;
                    w_mem_addr_nxt  = w_pick_d ? d_addr : i_addr;
                    w_mem_wdata_nxt = w_pick_d ? d_wdata : i_wdata;
                    w_mem_write_nxt = w_pick_d ? d_write : i_write;
                    // A write wins when read and write arrive together
                    w_mem_read_nxt  = w_pick_d ? (d_read & ~d_write)
                                               : (i_read & ~i_write);
                end
            end
            GRANT_I, GRANT_D: begin
                if (mem_resp) begin
                    w_state_nxt     = IDLE;
                    w_mem_read_nxt  = 1'b0;
                    w_mem_write_nxt = 1'b0;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign mem_read  = r_mem_read;
    assign mem_write = r_mem_write;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign i_resp    = (r_state == GRANT_I) & mem_resp;
    assign d_resp    = (r_state == GRANT_D) & mem_resp;
    assign i_rdata   = mem_rdata;
    assign d_rdata   = mem_rdata;
endmodule

// File: tb/tb_cache_arbiter.sv
// Testbench for cache_arbiter: directed scenarios plus a randomized
// run against a transaction-level model of the grant rules.
module tb_cache_arbiter;
    localparam int AW = 32;
    localparam int LW = 256;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          i_read = 1'b0;
    logic          i_write = 1'b0;
    logic [AW-1:0] i_addr = '0;
    logic [LW-1:0] i_wdata = '0;
    logic [LW-1:0] i_rdata;
    logic          i_resp;
    logic          d_read = 1'b0;
    logic          d_write = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [LW-1:0] d_wdata = '0;
    logic [LW-1:0] d_rdata;
    logic          d_resp;
    logic          mem_read;
    logic          mem_write;
    logic [AW-1:0] mem_addr;
    logic [LW-1:0] mem_wdata;
    logic [LW-1:0] mem_rdata = '0;
    logic          mem_resp = 1'b0;

    int errors = 0;
    int checks = 0;

    // Model: who owns the port (0 none, 1 I, 2 D) and who won last.
    int            m_owner;
    bit            m_last_d;
    logic          m_rd;
    logic          m_wr;
    logic [AW-1:0] m_addr;
    logic [LW-1:0] m_wdata;

    cache_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_read(i_read), .i_write(i_write), .i_addr(i_addr),
        .i_wdata(i_wdata), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_rdata(d_rdata), .d_resp(d_resp),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_resp(mem_resp)
    );

    always #5 clk = ~clk;

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] v;
        for (int k = 0; k < LW / 32; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        i_read = 0; i_write = 0; i_addr = '0; i_wdata = '0;
        d_read = 0; d_write = 0; d_addr = '0; d_wdata = '0;
        mem_resp = 0; mem_rdata = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        #2;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic model_reset();
        m_owner = 0; m_last_d = 1'b1;
        m_rd = 0; m_wr = 0; m_addr = '0; m_wdata = '0;
    endtask

    // Apply one rising edge to the model using current bench inputs.
    task automatic model_edge();
        bit ia, da, win_d;
        if (m_owner == 0) begin
            ia = i_read | i_write;
            da = d_read | d_write;
            if (ia || da) begin
                win_d = (ia && da) ? !m_last_d : da;
                m_owner = win_d ? 2 : 1;
                m_last_d = win_d;
                m_wr = win_d ? d_write : i_write;
                m_rd = win_d ? (d_read && !d_write) : (i_read && !i_write);
                m_addr = win_d ? d_addr : i_addr;
                m_wdata = win_d ? d_wdata : i_wdata;
            end
        end else if (mem_resp) begin
            m_owner = 0; m_rd = 0; m_wr = 0;
        end
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        mem_resp = 1'b1;
        #2;
        checks++;
        if ({mem_read, mem_write, mem_addr} !== {2'b00, 32'h0}) begin
            errors++;
            $display("FAIL reset_regs: got rd=%b wr=%b addr=%h want 0 0 0",
                     mem_read, mem_write, mem_addr);
        end
        checks++;
        if (mem_wdata !== '0) begin
            errors++;
            $display("FAIL reset_wdata: got %h want 0", mem_wdata);
        end
        checks++;
        if ({i_resp, d_resp} !== 2'b00) begin
            errors++;
            $display("FAIL reset_resp: got i=%b d=%b want 0 0", i_resp, d_resp);
        end
        mem_resp = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single_read();
        logic [LW-1:0] pat;
        pat = {32{8'hA5}};
        i_read = 1; i_addr = 32'h100;
        for (int c = 0; c < 3; c++) begin
            cyc();
            if (c == 2) begin
                mem_resp = 1; mem_rdata = pat; i_read = 0;
            end
            #1;
            checks++;
            if ({mem_read, mem_write, mem_addr} !== {2'b10, 32'h100}) begin
                errors++;
                $display("FAIL single_grant c%0d: got rd=%b wr=%b addr=%h want 1 0 100",
                         c, mem_read, mem_write, mem_addr);
            end
            checks++;
            if ({i_resp, d_resp} !== {(c == 2), 1'b0}) begin
                errors++;
                $display("FAIL single_resp c%0d: got i=%b d=%b want %b 0",
                         c, i_resp, d_resp, (c == 2));
            end
        end
        checks++;
        if (i_rdata !== pat) begin
            errors++;
            $display("FAIL single_rdata: got %h want %h", i_rdata, pat);
        end
        cyc();
        mem_resp = 0;
        #1;
        checks++;
        if ({mem_read, mem_write, i_resp} !== 3'b000) begin
            errors++;
            $display("FAIL single_done: got rd=%b wr=%b i_resp=%b want 0 0 0",
                     mem_read, mem_write, i_resp);
        end
    endtask

    task automatic test_tie();
        do_reset();
        i_read = 1; i_addr = 32'h300;
        d_read = 1; d_addr = 32'h400;
        cyc();
        #1;
        checks++;
        if ({mem_read, mem_addr} !== {1'b1, 32'h300}) begin
            errors++;
            $display("FAIL tie_first: got rd=%b addr=%h want 1 300", mem_read, mem_addr);
        end
        mem_resp = 1; i_read = 0;
        #1;
        checks++;
        if ({i_resp, d_resp} !== 2'b10) begin
            errors++;
            $display("FAIL tie_iresp: got i=%b d=%b want 1 0", i_resp, d_resp);
        end
        cyc();
        mem_resp = 0;
        #1;
        checks++;
        if (mem_read !== 1'b0) begin
            errors++;
            $display("FAIL tie_gap: got rd=%b want 0", mem_read);
        end
        cyc();
        #1;
        checks++;
        if ({mem_read, mem_addr} !== {1'b1, 32'h400}) begin
            errors++;
            $display("FAIL tie_second: got rd=%b addr=%h want 1 400", mem_read, mem_addr);
        end
        mem_resp = 1; d_read = 0;
        #1;
        checks++;
        if ({i_resp, d_resp} !== 2'b01) begin
            errors++;
            $display("FAIL tie_dresp: got i=%b d=%b want 0 1", i_resp, d_resp);
        end
        cyc();
        mem_resp = 0;
    endtask

    task automatic test_alternation();
        logic [AW-1:0] exp_addr;
        do_reset();
        i_read = 1; i_addr = 32'h700;
        d_read = 1; d_addr = 32'h800;
        for (int k = 0; k < 4; k++) begin
            exp_addr = (k % 2 == 1) ? 32'h800 : 32'h700;
            cyc();
            #1;
            checks++;
            if ({mem_read, mem_addr} !== {1'b1, exp_addr}) begin
                errors++;
                $display("FAIL alt_grant k%0d: got rd=%b addr=%h want 1 %h",
                         k, mem_read, mem_addr, exp_addr);
            end
            mem_resp = 1;
            #1;
            checks++;
            if ({i_resp, d_resp} !== {(k % 2 == 0), (k % 2 == 1)}) begin
                errors++;
                $display("FAIL alt_resp k%0d: got i=%b d=%b", k, i_resp, d_resp);
            end
            cyc();
            mem_resp = 0;
            #1;
            checks++;
            if (mem_read !== 1'b0) begin
                errors++;
                $display("FAIL alt_gap k%0d: got rd=%b want 0", k, mem_read);
            end
        end
        i_read = 0; d_read = 0;
        cyc();
    endtask

    task automatic test_writeback();
        logic [LW-1:0] pat;
        logic [LW-1:0] fill;
        pat = {16{16'hC3E1}};
        fill = rand_line();
        d_write = 1; d_addr = 32'h200; d_wdata = pat;
        cyc();
        for (int c = 0; c < 2; c++) begin
            if (c == 1) begin
                i_read = 1; i_addr = 32'h900;
            end
            #1;
            checks++;
            if ({mem_read, mem_write, mem_addr, mem_wdata} !== {2'b01, 32'h200, pat}) begin
                errors++;
                $display("FAIL wb_write c%0d: got rd=%b wr=%b addr=%h wdata=%h",
                         c, mem_read, mem_write, mem_addr, mem_wdata);
            end
            if (c == 0) cyc();
        end
        mem_resp = 1;
        #1;
        checks++;
        if ({i_resp, d_resp} !== 2'b01) begin
            errors++;
            $display("FAIL wb_dresp: got i=%b d=%b want 0 1", i_resp, d_resp);
        end
        cyc();
        mem_resp = 0; d_write = 0; d_read = 1; d_addr = 32'h240;
        #1;
        checks++;
        if ({mem_read, mem_write} !== 2'b00) begin
            errors++;
            $display("FAIL wb_gap: got rd=%b wr=%b want 0 0", mem_read, mem_write);
        end
        cyc();
        #1;
        checks++;
        if ({mem_read, mem_write, mem_addr} !== {2'b10, 32'h900}) begin
            errors++;
            $display("FAIL wb_iread: got rd=%b wr=%b addr=%h want 1 0 900",
                     mem_read, mem_write, mem_addr);
        end
        mem_resp = 1; i_read = 0;
        #1;
        checks++;
        if ({i_resp, d_resp} !== 2'b10) begin
            errors++;
            $display("FAIL wb_iresp: got i=%b d=%b want 1 0", i_resp, d_resp);
        end
        cyc();
        mem_resp = 0;
        cyc();
        #1;
        checks++;
        if ({mem_read, mem_write, mem_addr} !== {2'b10, 32'h240}) begin
            errors++;
            $display("FAIL wb_fill: got rd=%b wr=%b addr=%h want 1 0 240",
                     mem_read, mem_write, mem_addr);
        end
        mem_resp = 1; mem_rdata = fill; d_read = 0;
        #1;
        checks++;
        if ({d_resp, d_rdata} !== {1'b1, fill}) begin
            errors++;
            $display("FAIL wb_fill_data: got resp=%b data=%h want 1 %h", d_resp, d_rdata, fill);
        end
        cyc();
        mem_resp = 0;
    endtask

    task automatic test_reset_mid();
        i_wdata = '0; d_wdata = '0;
        d_read = 1; d_addr = 32'h600;
        cyc();
        #1;
        checks++;
        if ({mem_read, mem_addr} !== {1'b1, 32'h600}) begin
            errors++;
            $display("FAIL rmid_grant: got rd=%b addr=%h want 1 600", mem_read, mem_addr);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({mem_read, mem_write, mem_addr} !== {2'b00, 32'h0}) begin
            errors++;
            $display("FAIL rmid_async: got rd=%b wr=%b addr=%h want 0 0 0",
                     mem_read, mem_write, mem_addr);
        end
        @(negedge clk);
        rst_n = 1'b1; d_read = 0; mem_resp = 1;
        #1;
        checks++;
        if ({i_resp, d_resp} !== 2'b00) begin
            errors++;
            $display("FAIL rmid_late_resp: got i=%b d=%b want 0 0", i_resp, d_resp);
        end
        cyc();
        mem_resp = 0;
        i_read = 1; i_addr = 32'h104;
        cyc();
        #1;
        checks++;
        if ({mem_read, mem_addr} !== {1'b1, 32'h104}) begin
            errors++;
            $display("FAIL rmid_idle: got rd=%b addr=%h want 1 104", mem_read, mem_addr);
        end
        mem_resp = 1; i_read = 0;
        cyc();
        mem_resp = 0;
    endtask

    task automatic test_stray_resp();
        mem_resp = 1; mem_rdata = rand_line();
        #1;
        checks++;
        if ({i_resp, d_resp} !== 2'b00) begin
            errors++;
            $display("FAIL stray_resp: got i=%b d=%b want 0 0", i_resp, d_resp);
        end
        cyc();
        cyc();
        mem_resp = 0;
        #1;
        checks++;
        if ({mem_read, mem_write, mem_addr, mem_wdata} !== {2'b00, 32'h104, 256'h0}) begin
            errors++;
            $display("FAIL stray_regs: got rd=%b wr=%b addr=%h wdata=%h",
                     mem_read, mem_write, mem_addr, mem_wdata);
        end
        // last winner was I, so D must win this tie
        i_read = 1; i_addr = 32'hA00;
        d_read = 1; d_addr = 32'hB00;
        cyc();
        #1;
        checks++;
        if ({mem_read, mem_addr} !== {1'b1, 32'hB00}) begin
            errors++;
            $display("FAIL stray_last: got rd=%b addr=%h want 1 b00", mem_read, mem_addr);
        end
        mem_resp = 1; i_read = 0; d_read = 0;
        cyc();
        mem_resp = 0;
        cyc();
    endtask

    task automatic test_random();
        bit ipend, dpend, idone, ddone;
        int r;
        do_reset();
        model_reset();
        ipend = 0; dpend = 0;
        for (int n = 0; n < 600; n++) begin
            if (!ipend && ($urandom % 3 == 0)) begin
                r = $urandom % 3;
                i_read = (r != 1); i_write = (r != 0);
                i_addr = $urandom; i_wdata = rand_line();
                ipend = 1;
            end
            if (!dpend && ($urandom % 3 == 0)) begin
                r = $urandom % 3;
                d_read = (r != 1); d_write = (r != 0);
                d_addr = $urandom; d_wdata = rand_line();
                dpend = 1;
            end
            mem_resp = (m_owner != 0) ? ($urandom % 3 == 0) : ($urandom % 8 == 0);
            mem_rdata = rand_line();
            #1;
            checks++;
            if ({i_resp, d_resp} !== {(m_owner == 1) && mem_resp, (m_owner == 2) && mem_resp}) begin
                errors++;
                $display("FAIL rnd_resp n%0d: got i=%b d=%b owner=%0d mem_resp=%b",
                         n, i_resp, d_resp, m_owner, mem_resp);
            end
            checks++;
            if ({i_rdata, d_rdata} !== {mem_rdata, mem_rdata}) begin
                errors++;
                $display("FAIL rnd_rdata n%0d: got i=%h d=%h want %h",
                         n, i_rdata, d_rdata, mem_rdata);
            end
            checks++;
            if ({mem_read, mem_write, mem_addr} !== {m_rd, m_wr, m_addr}) begin
                errors++;
                $display("FAIL rnd_req n%0d: got rd=%b wr=%b addr=%h want %b %b %h",
                         n, mem_read, mem_write, mem_addr, m_rd, m_wr, m_addr);
            end
            checks++;
            if (mem_wdata !== m_wdata) begin
                errors++;
                $display("FAIL rnd_wdata n%0d: got %h want %h", n, mem_wdata, m_wdata);
            end
            checks++;
            if ((mem_read & mem_write) !== 1'b0) begin
                errors++;
                $display("FAIL rnd_exclusive n%0d: got rd=%b wr=%b", n, mem_read, mem_write);
            end
            idone = (m_owner == 1) && mem_resp;
            ddone = (m_owner == 2) && mem_resp;
            @(posedge clk);
            model_edge();
            @(negedge clk);
            if (idone) begin
                i_read = 0; i_write = 0; ipend = 0;
            end
            if (ddone) begin
                d_read = 0; d_write = 0; dpend = 0;
            end
        end
        clear_inputs();
        cyc();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_tie();
        test_alternation();
        test_writeback();
        test_reset_mid();
        test_stray_resp();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
